// File: rtl/mem_1r1w_bwe_if.sv
// Read/write port bundle for mem_1r1w_bwe; RDATA stays a plain port so OEN can tri-state it.
interface mem_1r1w_bwe_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned ADDR_W = 13
);
    localparam int unsigned NB = DATA_W / BYTE_W;

    logic              BUSY;
    logic              RCEN;
    logic [ADDR_W-1:0] RADDR;
    logic              RVALID;
    logic              OEN;
    logic              WCEN;
    logic [NB-1:0]     WBEN;
    logic [ADDR_W-1:0] WADDR;
    logic [DATA_W-1:0] WDATA;

    modport master (
        input  BUSY, RVALID,
        output RCEN, RADDR, OEN, WCEN, WBEN, WADDR, WDATA
    );

    modport slave (
        output BUSY, RVALID,
        input  RCEN, RADDR, OEN, WCEN, WBEN, WADDR, WDATA
    );
endinterface

// File: rtl/mem_1r1w_bwe.sv
// Synchronous 1R1W RAM with active-low byte-lane write enables, 1- or 2-cycle read
// latency, selectable read-during-write policy and optional clear sweep after reset.
module mem_1r1w_bwe #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned BYTE_W     = 8,
    parameter int unsigned DEPTH      = 8192,
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned CLR_ON_RST = 1
) (
    input  logic              CLK,
    input  logic              RST,
    mem_1r1w_bwe_if.slave     bus,
    output logic [DATA_W-1:0] RDATA
);
    localparam int unsigned NB    = DATA_W / BYTE_W;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AW1   = ADDR_W + 1;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              clr_last_c, clr_en_c, ready_c;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] lane_mask_c;
    logic [DATA_W-1:0] wr_word_c, rd_old_c, rd_word_c;
    logic [IDX_W-1:0]  widx_c, ridx_c, cidx_c;
    logic              wr_in_rng_c, rd_in_rng_c, wr_en_c, rd_en_c, collide_c;

    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    assign clr_last_c = (clr_cnt_q == ADDR_W'(DEPTH - 1));

    // State register: reset lands in CLEAR or READY depending on CLR_ON_RST
    always_ff @(posedge CLK) begin
        if (RST) state_q <= (CLR_ON_RST != 0) ? S_CLEAR : S_READY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_CLEAR && clr_last_c) state_d = S_READY;
    end

    always_comb begin
        clr_en_c = 1'b0;
        ready_c  = 1'b0;
        case (state_q)
            S_CLEAR: clr_en_c = 1'b1;
            S_READY: ready_c  = 1'b1;
            default: ;
        endcase
    end

    // Sweep counter holds at DEPTH-1 so it never wraps past the array
    always_ff @(posedge CLK) begin
        if (RST)                           clr_cnt_q <= '0;
        else if (clr_en_c && !clr_last_c)  clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
    end

    always_comb begin
        lane_mask_c = '0;
        for (int b = 0; b < NB; b++) begin
            lane_mask_c[b*BYTE_W +: BYTE_W] = {BYTE_W{~bus.WBEN[b]}};
        end
    end

    assign wr_in_rng_c = ({1'b0, bus.WADDR} < AW1'(DEPTH));
    assign rd_in_rng_c = ({1'b0, bus.RADDR} < AW1'(DEPTH));
    assign widx_c      = bus.WADDR[IDX_W-1:0];
    assign ridx_c      = bus.RADDR[IDX_W-1:0];
    assign cidx_c      = clr_cnt_q[IDX_W-1:0];
    assign wr_en_c     = ready_c && !RST && !bus.WCEN && wr_in_rng_c;
    assign rd_en_c     = ready_c && !RST && !bus.RCEN;
    assign collide_c   = wr_en_c && (bus.WADDR == bus.RADDR);

    // Merged word: enabled lanes from WDATA, others from the current array contents
    assign wr_word_c = (bus.WDATA & lane_mask_c) | (mem_q[widx_c] & ~lane_mask_c);
    assign rd_old_c  = mem_q[ridx_c];

    always_comb begin
        rd_word_c = rd_old_c;
        if (!rd_in_rng_c)                    rd_word_c = '0;
        else if (RDW_MODE == 0 && collide_c) rd_word_c = wr_word_c;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (clr_en_c)     mem_q[cidx_c] <= '0;
            else if (wr_en_c) mem_q[widx_c] <= wr_word_c;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] p1_data_q;
            logic              p1_vld_q;

            // Extra stage; reset drops any read still in flight
            always_ff @(posedge CLK) begin
                if (RST) begin
                    p1_data_q <= '0;
                    p1_vld_q  <= 1'b0;
                    rdata_q   <= '0;
                    rvalid_q  <= 1'b0;
                end else begin
                    p1_vld_q <= rd_en_c;
                    if (rd_en_c) p1_data_q <= rd_word_c;
                    rvalid_q <= p1_vld_q;
                    if (p1_vld_q) rdata_q <= p1_data_q;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge CLK) begin
                if (RST) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_en_c;
                    if (rd_en_c) rdata_q <= rd_word_c;
                end
            end
        end
    endgenerate

    assign bus.BUSY   = clr_en_c;
    assign bus.RVALID = rvalid_q;
    assign RDATA      = bus.OEN ? {DATA_W{1'bz}} : rdata_q;
endmodule
